// File: rtl/vreg_seq_pkg.sv
// Shared definitions for the vector register-group sequencer.
//   state_e      : sequencer FSM states
//   vlmul_count  : vlmul encoding -> number of physical registers in a group
//   NREG         : register count for the default address width
package vreg_seq_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 5;
    localparam int unsigned NREG           = 2 ** ADDR_WIDTH_DEF;
    localparam int unsigned MAX_GROUP      = 8;
    localparam int unsigned CNT_W          = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HAZARD = 2'd1,
        ISSUE  = 2'd2
    } state_e;

    // Fractional/reserved encodings (vlmul[2]=1) occupy a single register.
    function automatic logic [CNT_W-1:0] vlmul_count(input logic [2:0] vlmul);
        if (vlmul[2]) begin
            return CNT_W'(1);
        end
        return CNT_W'(CNT_W'(1) << vlmul[1:0]);
    endfunction

endpackage

// File: rtl/vreg_group_mask.sv
// Wrapped register-group mask: sets bits base .. base+count-1 modulo NREG.
//   base   : group base register
//   count  : registers in the group (1..MAX_GROUP)
//   mask_c : NREG-bit combinational mask
module vreg_group_mask
    import vreg_seq_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic [ADDR_WIDTH-1:0]      base,
    input  logic [CNT_W-1:0]           count,
    output logic [(2**ADDR_WIDTH)-1:0] mask_c
);

    // Address arithmetic is ADDR_WIDTH wide, so groups past the top wrap to 0.
    always_comb begin
        mask_c = '0;
        for (int unsigned i = 0; i < MAX_GROUP; i++) begin
            if (CNT_W'(i) < count) begin
                mask_c[ADDR_WIDTH'(base + ADDR_WIDTH'(i))] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vreg_group_sequencer.sv
// Issue controller for vector register-group instructions. Latches one
// instruction, stalls while any used operand group overlaps the write-in-flight
// scoreboard, then streams one micro-op per physical register.
//   in_*        : instruction offer (valid/ready, group bases, use flags, vlmul)
//   flush       : synchronous abort of the current instruction
//   uop_*       : micro-op stream (valid/ready, per-register addresses, first/last)
//   wb_valid/addr : completed register write, clears its busy bit
//   busy        : scoreboard, bit i = write to register i in flight
//   idle        : no instruction held and scoreboard empty
module vreg_group_sequencer
    import vreg_seq_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [ADDR_WIDTH-1:0]       in_vd,
    input  logic [ADDR_WIDTH-1:0]       in_vs1,
    input  logic [ADDR_WIDTH-1:0]       in_vs2,
    input  logic                        in_use_vs1,
    input  logic                        in_use_vs2,
    input  logic                        in_use_vd,
    input  logic [2:0]                  in_vlmul,
    input  logic                        flush,
    output logic                        uop_valid,
    input  logic                        uop_ready,
    output logic [ADDR_WIDTH-1:0]       uop_vd,
    output logic [ADDR_WIDTH-1:0]       uop_vs1,
    output logic [ADDR_WIDTH-1:0]       uop_vs2,
    output logic                        uop_first,
    output logic                        uop_last,
    input  logic                        wb_valid,
    input  logic [ADDR_WIDTH-1:0]       wb_addr,
    output logic [(2**ADDR_WIDTH)-1:0]  busy,
    output logic                        idle
);

    localparam int unsigned NREG_W = 2 ** ADDR_WIDTH;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   vd_q, vd_d, vs1_q, vs1_d, vs2_q, vs2_d;
    logic                    use_vs1_q, use_vs1_d, use_vs2_q, use_vs2_d, use_vd_q, use_vd_d;
    logic [CNT_W-1:0]        count_q, count_d, offset_q, offset_d;

    logic                    in_ready_d, uop_valid_d, uop_first_d, uop_last_d, idle_d;
    logic [ADDR_WIDTH-1:0]   uop_vd_d, uop_vs1_d, uop_vs2_d;
    logic [NREG_W-1:0]       busy_d, set_vec, clr_vec;
    logic [NREG_W-1:0]       mask_vd, mask_vs1, mask_vs2;
    logic                    hazard_c, handshake, last_c;

    vreg_group_mask #(.ADDR_WIDTH(ADDR_WIDTH)) u_mask_vs1 (.base(vs1_q), .count(count_q), .mask_c(mask_vs1));
    vreg_group_mask #(.ADDR_WIDTH(ADDR_WIDTH)) u_mask_vs2 (.base(vs2_q), .count(count_q), .mask_c(mask_vs2));
    vreg_group_mask #(.ADDR_WIDTH(ADDR_WIDTH)) u_mask_vd  (.base(vd_q),  .count(count_q), .mask_c(mask_vd));

    // Hazard check uses only latched operands and the registered scoreboard.
    assign hazard_c = (use_vs1_q && (|(mask_vs1 & busy)))
                   || (use_vs2_q && (|(mask_vs2 & busy)))
                   || (use_vd_q  && (|(mask_vd  & busy)));

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            vd_q      <= '0;
            vs1_q     <= '0;
            vs2_q     <= '0;
            use_vs1_q <= 1'b0;
            use_vs2_q <= 1'b0;
            use_vd_q  <= 1'b0;
            count_q   <= CNT_W'(1);
            offset_q  <= '0;
            in_ready  <= 1'b1;
            uop_valid <= 1'b0;
            uop_vd    <= '0;
            uop_vs1   <= '0;
            uop_vs2   <= '0;
            uop_first <= 1'b0;
            uop_last  <= 1'b0;
            busy      <= '0;
            idle      <= 1'b1;
        end else begin
            state_q   <= state_d;
            vd_q      <= vd_d;
            vs1_q     <= vs1_d;
            vs2_q     <= vs2_d;
            use_vs1_q <= use_vs1_d;
            use_vs2_q <= use_vs2_d;
            use_vd_q  <= use_vd_d;
            count_q   <= count_d;
            offset_q  <= offset_d;
            in_ready  <= in_ready_d;
            uop_valid <= uop_valid_d;
            uop_vd    <= uop_vd_d;
            uop_vs1   <= uop_vs1_d;
            uop_vs2   <= uop_vs2_d;
            uop_first <= uop_first_d;
            uop_last  <= uop_last_d;
            busy      <= busy_d;
            idle      <= idle_d;
        end
    end

    // Next-state, scoreboard and output decode.
    always_comb begin
        state_d     = state_q;
        vd_d        = vd_q;
        vs1_d       = vs1_q;
        vs2_d       = vs2_q;
        use_vs1_d   = use_vs1_q;
        use_vs2_d   = use_vs2_q;
        use_vd_d    = use_vd_q;
        count_d     = count_q;
        offset_d    = offset_q;
        uop_valid_d = uop_valid;
        uop_vd_d    = uop_vd;
        uop_vs1_d   = uop_vs1;
        uop_vs2_d   = uop_vs2;
        uop_first_d = uop_first;
        uop_last_d  = uop_last;
        set_vec     = '0;
        clr_vec     = '0;

        // A flushed handshake is dropped entirely, including its busy bit.
        handshake = (state_q == ISSUE) && uop_valid && uop_ready && !flush;
        last_c    = (offset_q == CNT_W'(count_q - CNT_W'(1)));

        if (wb_valid) begin
            clr_vec[wb_addr] = 1'b1;
        end
        if (handshake && use_vd_q) begin
            set_vec[uop_vd] = 1'b1;
        end
        // Set is OR-ed last so it wins over a same-cycle clear.
        busy_d = (busy & ~clr_vec) | set_vec;

        unique case (state_q)
            IDLE: begin
                if (in_valid && !flush) begin
                    vd_d      = in_vd;
                    vs1_d     = in_vs1;
                    vs2_d     = in_vs2;
                    use_vs1_d = in_use_vs1;
                    use_vs2_d = in_use_vs2;
                    use_vd_d  = in_use_vd;
                    count_d   = vlmul_count(in_vlmul);
                    offset_d  = '0;
                    state_d   = HAZARD;
                end
            end
            HAZARD: begin
                if (!hazard_c) begin
                    state_d     = ISSUE;
                    uop_valid_d = 1'b1;
                    uop_vd_d    = vd_q;
                    uop_vs1_d   = vs1_q;
                    uop_vs2_d   = vs2_q;
                    uop_first_d = 1'b1;
                    uop_last_d  = (count_q == CNT_W'(1));
                end
            end
            ISSUE: begin
                if (handshake) begin
                    if (last_c) begin
                        state_d     = IDLE;
                        uop_valid_d = 1'b0;
                        uop_first_d = 1'b0;
                        uop_last_d  = 1'b0;
                    end else begin
                        offset_d    = CNT_W'(offset_q + CNT_W'(1));
                        uop_vd_d    = ADDR_WIDTH'(uop_vd  + ADDR_WIDTH'(1));
                        uop_vs1_d   = ADDR_WIDTH'(uop_vs1 + ADDR_WIDTH'(1));
                        uop_vs2_d   = ADDR_WIDTH'(uop_vs2 + ADDR_WIDTH'(1));
                        uop_first_d = 1'b0;
                        uop_last_d  = (CNT_W'(offset_q + CNT_W'(2)) == count_q);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (flush) begin
            state_d     = IDLE;
            uop_valid_d = 1'b0;
            uop_first_d = 1'b0;
            uop_last_d  = 1'b0;
        end

        in_ready_d = (state_d == IDLE);
        idle_d     = (state_d == IDLE) && (busy_d == '0);
    end

endmodule

// File: tb/tb_vreg_group_sequencer.sv
// Self-checking bench for vreg_group_sequencer: directed scenarios followed by
// randomized instructions, checked against a transaction-level model.
module tb_vreg_group_sequencer;

    localparam int AW   = 5;
    localparam int NR   = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] in_vd = '0, in_vs1 = '0, in_vs2 = '0;
    logic          in_use_vs1 = 1'b0, in_use_vs2 = 1'b0, in_use_vd = 1'b0;
    logic [2:0]    in_vlmul = '0;
    logic          flush = 1'b0;
    logic          uop_valid;
    logic          uop_ready = 1'b0;
    logic [AW-1:0] uop_vd, uop_vs1, uop_vs2;
    logic          uop_first, uop_last;
    logic          wb_valid = 1'b0;
    logic [AW-1:0] wb_addr = '0;
    logic [NR-1:0] busy;
    logic          idle;

    int            tests = 0;
    int            fails = 0;
    logic [NR-1:0] m_busy = '0;

    always #5 clk = ~clk;

    vreg_group_sequencer #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_vd(in_vd), .in_vs1(in_vs1), .in_vs2(in_vs2),
        .in_use_vs1(in_use_vs1), .in_use_vs2(in_use_vs2), .in_use_vd(in_use_vd),
        .in_vlmul(in_vlmul), .flush(flush),
        .uop_valid(uop_valid), .uop_ready(uop_ready),
        .uop_vd(uop_vd), .uop_vs1(uop_vs1), .uop_vs2(uop_vs2),
        .uop_first(uop_first), .uop_last(uop_last),
        .wb_valid(wb_valid), .wb_addr(wb_addr),
        .busy(busy), .idle(idle)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NR-1:0] gmask(input int base, input int n);
        logic [NR-1:0] m = '0;
        for (int i = 0; i < n; i++) m[(base + i) % NR] = 1'b1;
        return m;
    endfunction

    function automatic int pick_bit(input logic [NR-1:0] v, input int start);
        for (int k = 0; k < NR; k++) begin
            if (v[(start + k) % NR]) return (start + k) % NR;
        end
        return -1;
    endfunction

    // Advance one clock; model scoreboard: clear first, then set (set wins).
    task automatic tick(input bit do_set, input int set_addr);
        logic [NR-1:0] nb;
        nb = m_busy;
        if (wb_valid) nb[wb_addr] = 1'b0;
        if (do_set) nb[set_addr] = 1'b1;
        @(posedge clk);
        #1;
        m_busy   = nb;
        wb_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 1);
        chk({tag, "_uop_valid"}, 32'(uop_valid), 0);
        chk({tag, "_uop_vd"}, 32'(uop_vd), 0);
        chk({tag, "_first_last"}, {30'd0, uop_first, uop_last}, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_idle"}, 32'(idle), 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_vals("reset");
        m_busy = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // mode: 0 random ready/wb, 1 clean, 2 backpressure at offset 2, 3 set/clear collision
    task automatic run_instr(input int vd, input int vs1, input int vs2,
                             input bit u1, input bit u2, input bit ud,
                             input int vlmul, input int mode, input int flush_at);
        int n, hc, off, cyc, stall, idx;
        bit rdy;
        logic [NR-1:0] hmask;
        n = (vlmul >= 4) ? 1 : (1 << vlmul);
        hmask = (u1 ? gmask(vs1, n) : '0) | (u2 ? gmask(vs2, n) : '0) | (ud ? gmask(vd, n) : '0);

        chk("accept_in_ready", 32'(in_ready), 1);
        in_valid = 1'b1; in_vd = AW'(vd); in_vs1 = AW'(vs1); in_vs2 = AW'(vs2);
        in_use_vs1 = u1; in_use_vs2 = u2; in_use_vd = ud; in_vlmul = 3'(vlmul);
        tick(0, 0);
        in_valid = 1'b0;

        // Stall phase: one cycle minimum, longer while operands overlap busy.
        hc = 0;
        forever begin
            chk("hazard_uop_valid", 32'(uop_valid), 0);
            chk("hazard_in_ready", 32'(in_ready), 0);
            chk("hazard_busy", busy, m_busy);
            if ((m_busy & hmask) == '0) begin
                tick(0, 0);
                break;
            end
            if (hc > 400) begin
                fails++;
                $error("FAIL hazard_bound observed=%0d cycles expected release", hc);
                return;
            end
            idx = -1;
            if (mode == 0) begin
                if ($urandom % 2 == 0) idx = pick_bit(m_busy, int'($urandom % NR));
            end else if (hc >= 3) begin
                idx = pick_bit(m_busy & hmask, 0);
            end
            if (idx >= 0) begin
                wb_valid = 1'b1;
                wb_addr  = AW'(idx);
            end
            tick(0, 0);
            hc++;
        end

        off = 0; cyc = 0; stall = 0;
        while (off < n) begin
            chk("issue_uop_valid", 32'(uop_valid), 1);
            chk("issue_in_ready", 32'(in_ready), 0);
            chk("uop_vd", 32'(uop_vd), (vd + off) % NR);
            chk("uop_vs1", 32'(uop_vs1), (vs1 + off) % NR);
            chk("uop_vs2", 32'(uop_vs2), (vs2 + off) % NR);
            chk("uop_first", 32'(uop_first), (off == 0) ? 1 : 0);
            chk("uop_last", 32'(uop_last), (off == n - 1) ? 1 : 0);
            chk("issue_busy", busy, m_busy);
            if (cyc > 200) begin
                fails++;
                $error("FAIL issue_bound observed=%0d cycles expected completion", cyc);
                return;
            end
            if (off == flush_at) begin
                flush = 1'b1;
                uop_ready = 1'b1;
                tick(0, 0);
                flush = 1'b0;
                uop_ready = 1'b0;
                break;
            end
            case (mode)
                0: begin
                    rdy = ($urandom % 4) != 0;
                    if ($urandom % 4 == 0) begin
                        wb_valid = 1'b1;
                        wb_addr  = AW'($urandom % NR);
                    end
                end
                2: begin
                    rdy = !(off == 2 && stall < 3);
                    if (!rdy) stall++;
                end
                3: begin
                    rdy = 1'b1;
                    if (off == 1) begin
                        wb_valid = 1'b1;
                        wb_addr  = AW'((vd + 1) % NR);
                    end
                end
                default: rdy = 1'b1;
            endcase
            uop_ready = rdy;
            tick(rdy && ud, (vd + off) % NR);
            if (rdy) off++;
            cyc++;
        end
        uop_ready = 1'b0;

        chk("done_uop_valid", 32'(uop_valid), 0);
        chk("done_in_ready", 32'(in_ready), 1);
        chk("done_busy", busy, m_busy);
        chk("done_idle", 32'(idle), (m_busy == '0) ? 1 : 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("por");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic 4-register group on an empty scoreboard.
        run_instr(4, 8, 12, 1, 1, 1, 2, 1, -1);
        chk("group4_busy", busy, 32'h0000_00F0);

        // Group crossing the top of the register file.
        run_instr(28, 0, 0, 0, 0, 1, 3, 1, -1);
        chk("wrap_busy", busy, 32'hF000_00FF);

        // RAW stall on busy[9], released by its writeback.
        run_instr(9, 0, 0, 0, 0, 1, 0, 1, -1);
        run_instr(0, 8, 0, 1, 0, 0, 1, 1, -1);

        // Backpressure mid-group.
        run_instr(16, 0, 0, 0, 0, 1, 2, 2, -1);

        // Same-cycle set and clear of one register.
        run_instr(20, 0, 0, 0, 0, 1, 1, 3, -1);
        chk("collision_bit", 32'(busy[21]), 1);

        // Flush after three handshakes of an 8-register group, then async reset.
        do_reset();
        run_instr(0, 0, 0, 0, 0, 1, 3, 1, 3);
        chk("flush_busy", busy, 32'h0000_0007);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async");
        m_busy = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Randomized instructions.
        for (int t = 0; t < 40; t++) begin
            run_instr(int'($urandom % NR), int'($urandom % NR), int'($urandom % NR),
                      bit'($urandom % 2), bit'($urandom % 2), ($urandom % 4) != 0,
                      int'($urandom % 8), 0, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vreg_group_sequencer.md
# vreg_group_sequencer

Issue controller for vector register-group operations. It accepts one vector instruction at a time (vd, vs1, vs2 group bases plus vlmul) and checks it against a write-in-flight scoreboard. It stalls on RAW/WAW hazards, then emits one micro-op per physical register of the group with incrementing addresses. It sits between instruction decode and the register-group address generator / vector register file ports, and replaces per-port address stepping with a single sequenced stream.

## Interface
- ADDR_WIDTH, 5: register address width; NREG = 2**ADDR_WIDTH registers.
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  instruction offered.
- in_ready  out  1  sequencer can accept; reset 1.
- in_vd / in_vs1 / in_vs2  in  ADDR_WIDTH each  group base addresses.
- in_use_vs1 / in_use_vs2 / in_use_vd  in  1 each  operand is read / written; unused operands are not hazard-checked.
- in_vlmul  in  3  vlmul encoding; vlmul[2]=1 (fractional or reserved) means 1 register, otherwise 2**vlmul registers (1/2/4/8).
- flush  in  1  synchronous abort of the current instruction.
- uop_valid  out  1  micro-op valid; reset 0.
- uop_ready  in  1  downstream accepts micro-op.
- uop_vd / uop_vs1 / uop_vs2  out  ADDR_WIDTH each  per-register addresses; reset 0.
- uop_first / uop_last  out  1 each  first/last micro-op of the group; reset 0.
- wb_valid  in  1  a register write has completed.
- wb_addr  in  ADDR_WIDTH  register whose busy bit is cleared.
- busy  out  NREG  scoreboard (bit i = write to register i in flight); reset 0.
- idle  out  1  state==IDLE and busy==0; reset 1.

## Operation
- States: IDLE, HAZARD, ISSUE. Reset state is IDLE.
- IDLE: in_ready=1. On in_valid, latch all in_* fields, set count=decode(vlmul), clear offset to 0, and go to HAZARD.
- HAZARD: in_ready=0, uop_valid=0. A hazard exists if (use_vs1 and mask(vs1) overlaps busy), or (use_vs2 and mask(vs2) overlaps busy), or (use_vd and mask(vd) overlaps busy). If there is no hazard, go to ISSUE. Otherwise stay and re-evaluate every cycle against the registered busy vector.
- mask(base) sets bits base .. base+count-1. Addition is modulo NREG, so a group that crosses the top wraps to register 0.
- ISSUE: uop_valid=1.
  - uop_vX = latched base + offset (mod NREG).
  - uop_first = (offset==0); uop_last = (offset==count-1).
  - Outputs hold stable while uop_valid && !uop_ready.
  - On handshake: offset++ and, if use_vd, set busy[uop_vd]. After the last handshake, go to IDLE.
- Scoreboard update per cycle: busy_next = (busy & ~clr) | set.
  - clr is the onehot of wb_addr when wb_valid.
  - set is the onehot of uop_vd on an accepted micro-op with use_vd.
  - If set and clear target the same bit, set wins.
  - wb_valid for a non-busy register is a no-op.
- flush (any state) forces IDLE and uop_valid=0 next cycle. Busy bits already set stay set. flush has priority over in_valid and the uop handshake in the same cycle: the handshake is dropped and its busy bit is not set.
- Async reset mid-operation forces IDLE, busy=0 and all outputs to their reset values immediately.

## Timing
- All outputs are registered or decoded from registered state only. No combinational path from in_valid/uop_ready/wb_* to outputs.
- Accept at edge E0 → HAZARD in cycle 1 → with no hazard, uop_valid=1 in cycle 2. Minimum issue latency is 2 cycles.
- A wb clear at edge Ek is visible to the hazard check in cycle k+1. A stall therefore releases no earlier than one cycle after the clearing write.
- An n-register group with uop_ready held high occupies ISSUE for n cycles. in_ready returns 1 the cycle after the last handshake.
- Throughput for back-to-back single-register instructions is one per 3 cycles. The block does not overlap instructions.

## Structure
- Shared package vreg_seq_pkg holds:
  - the state enum (IDLE/HAZARD/ISSUE);
  - the vlmul→count decode function;
  - the NREG constant.
- One sub-module, vreg_group_mask (base, count → NREG-bit wrapped mask), instantiated three times for vs1/vs2/vd.
- Scoreboard and FSM live in the top module.

## Test plan
- vlmul=3'b010, vd=4, vs1=8, vs2=12, uop_ready=1, empty scoreboard: uop_valid in cycle 2, then 4 micro-ops vd 4..7, vs1 8..11, vs2 12..15. first on op 0, last on op 3; busy = bits 4..7.
- RAW stall: busy[9]=1, then issue vlmul=1 with vs1=8. The sequencer stays in HAZARD. wb_valid, wb_addr=9 at edge k moves it to ISSUE at k+1; first micro-op is vs1=8.
- Wrap: vlmul=3'b011, vd=28: uop_vd sequence is 28,29,30,31,0,1,2,3 and busy has those 8 bits set.
- Backpressure: uop_ready low for 3 cycles mid-group. Outputs stay stable, offset does not advance, and no extra busy bits are set.
- Set/clear collision: wb_addr equals the uop_vd of a micro-op accepted in the same cycle. The busy bit ends at 1.
- flush during ISSUE of an 8-register group after 3 handshakes: next cycle IDLE, in_ready=1, busy keeps exactly those 3 bits. Asserting rst_n=0 then clears busy to 0 asynchronously.
